change_dispenser: RTL

- Output-side counterpart of the debounced coin-input path: converts the computed change amount into a timed sequence of single-coin dispense pulses, one denomination per pulse.
- Denominations are 50/20/10/5/1, the same set accepted on coin input.
- Sits between the vending state machine (start, change_money) and the board LEDs/coin actuators.
- Exposes the not-yet-dispensed amount so the display can count down.

---
 rtl/change_dispenser.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Turns a change amount into greedy single-coin dispense pulses (50/20/10/5/1).
// Optional `abort` input is enabled with CHANGE_DISPENSER_ABORT_EN.
module change_dispenser #(
    parameter int PULSE_CYCLES = 25_000_000,
    parameter int GAP_CYCLES   = 25_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic [7:0] change_money,
`ifdef CHANGE_DISPENSER_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy,
    output logic       done,
    output logic [7:0] remaining,
    output logic       coin_fifty,
    output logic       coin_twenty,
    output logic       coin_ten,
    output logic       coin_five,
    output logic       coin_one
);

    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        PULSE  = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rem_q, rem_d;
    logic [4:0]       coin_q, coin_d;   // one-hot {50,20,10,5,1}
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_hit;

`ifdef CHANGE_DISPENSER_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    function automatic logic [4:0] greedy(input logic [7:0] amt);
        if (amt >= 8'd50)      greedy = 5'b10000;
        else if (amt >= 8'd20) greedy = 5'b01000;
        else if (amt >= 8'd10) greedy = 5'b00100;
        else if (amt >= 8'd5)  greedy = 5'b00010;
        else if (amt >= 8'd1)  greedy = 5'b00001;
        else                   greedy = 5'b00000;
    endfunction

    function automatic logic [7:0] denom(input logic [4:0] oh);
        case (oh)
            5'b10000: denom = 8'd50;
            5'b01000: denom = 8'd20;
            5'b00100: denom = 8'd10;
            5'b00010: denom = 8'd5;
            5'b00001: denom = 8'd1;
            default:  denom = 8'd0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        coin_d  = coin_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (change_money != 8'd0) begin
                        rem_d   = change_money;
                        busy_d  = 1'b1;
                        state_d = SELECT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SELECT: begin
                coin_d  = greedy(rem_q);
                cnt_d   = PULSE_LOAD;
                state_d = PULSE;
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    // Amount drops in the same edge the coin output falls.
                    coin_d  = 5'b00000;
                    rem_d   = rem_q - denom(coin_q);
                    cnt_d   = GAP_LOAD;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = (rem_q != 8'd0) ? SELECT : DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                coin_d  = 5'b00000;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // An interrupted coin is not charged against the remaining amount.
        if (abort_hit && (state_q == SELECT || state_q == PULSE || state_q == GAP)) begin
            state_d = DONE;
            coin_d  = 5'b00000;
            rem_d   = rem_q;
            cnt_d   = '0;
        end

        done_d = (state_d == DONE);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= 8'd0;
            coin_q  <= 5'b00000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            coin_q  <= coin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign remaining   = rem_q;
    assign coin_fifty  = coin_q[4];
    assign coin_twenty = coin_q[3];
    assign coin_ten    = coin_q[2];
    assign coin_five   = coin_q[1];
    assign coin_one    = coin_q[0];

endmodule
